// File: rtl/bp_pkg.sv
// Shared types and helpers for the branch predictor update path.
package bp_pkg;

  localparam int HIST_W_DEFAULT = 12;

  typedef struct packed {
    logic                      lp;
    logic                      gp;
    logic                      cp;
    logic [HIST_W_DEFAULT-1:0] ghist;
  } pred_entry_t;

  // {train choice table, global predictor was the correct one}
  function automatic logic [1:0] choice_train(input logic lp, input logic gp, input logic taken);
    return {lp != gp, gp == taken};
  endfunction

endpackage

// File: rtl/bp_circ_buffer.sv
// Circular storage for in-flight predictions: array plus head/tail pointers.
module bp_circ_buffer #(
  parameter int DEPTH = 8,
  parameter int WIDTH = 15
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             wr_en,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             rd_en,
  input  logic             flush,
  output logic [WIDTH-1:0] rd_data
);

  localparam int PTR_W = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] head;
  logic [PTR_W-1:0] tail;

  assign rd_data = mem[head];

  always_ff @(posedge clock) begin
    if (wr_en) mem[tail] <= wr_data;
  end

  // DEPTH is a power of two, so pointer wrap is plain binary overflow.
  // A flush always coincides with popping the head, so the queue empties at head+1.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      head <= '0;
      tail <= '0;
    end else begin
      if (rd_en) head <= head + PTR_W'(1);
      if (flush) tail <= head + PTR_W'(1);
      else if (wr_en) tail <= tail + PTR_W'(1);
    end
  end

endmodule

// File: rtl/branch_update_queue.sv
// Pairs queued predictions with resolved outcomes and drives table training and recovery.
// Optional BUQ_STATS_EN adds saturating resolve/mispredict counters.
module branch_update_queue
  import bp_pkg::*;
#(
  parameter int DEPTH  = 8,
  parameter int HIST_W = HIST_W_DEFAULT,
  localparam int PTR_W = $clog2(DEPTH)
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              pred_valid,
  output logic              pred_ready,
  input  logic              pred_lp,
  input  logic              pred_gp,
  input  logic              pred_cp,
  input  logic [HIST_W-1:0] pred_ghist,
  input  logic              resolve_valid,
  input  logic              resolve_taken,
  output logic              upd_valid,
  output logic              upd_taken,
  output logic [HIST_W-1:0] upd_ghist,
  output logic              upd_choice_en,
  output logic              upd_choice_gp,
  output logic              mispredict,
  output logic [HIST_W-1:0] recover_ghist,
  output logic [PTR_W:0]    count,
  output logic              resolve_err
`ifdef BUQ_STATS_EN
  ,
  output logic [31:0]       stat_resolved,
  output logic [31:0]       stat_mispred
`endif
);

  localparam int ENTRY_W = HIST_W + 3;

  logic [ENTRY_W-1:0] head_raw;
  logic               head_lp, head_gp, head_cp;
  logic [HIST_W-1:0]  head_ghist;
  logic               do_push, do_pop, mis_now, push_keep;
  logic [1:0]         train;

  assign {head_lp, head_gp, head_cp, head_ghist} = head_raw;

  assign pred_ready = (count != (PTR_W+1)'(DEPTH));
  assign do_push    = pred_valid && pred_ready;
  assign do_pop     = resolve_valid && (count != '0);
  assign mis_now    = do_pop && (head_cp != resolve_taken);
  // Anything pushed alongside a mispredict is wrong-path and is dropped.
  assign push_keep  = do_push && !mis_now;
  assign train      = choice_train(head_lp, head_gp, resolve_taken);

  bp_circ_buffer #(.DEPTH(DEPTH), .WIDTH(ENTRY_W)) u_buf (
    .clock   (clock),
    .reset   (reset),
    .wr_en   (push_keep),
    .wr_data ({pred_lp, pred_gp, pred_cp, pred_ghist}),
    .rd_en   (do_pop),
    .flush   (mis_now),
    .rd_data (head_raw)
  );

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      count <= '0;
    end else if (mis_now) begin
      count <= '0;
    end else if (push_keep && !do_pop) begin
      count <= count + (PTR_W+1)'(1);
    end else if (do_pop && !push_keep) begin
      count <= count - (PTR_W+1)'(1);
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      upd_valid     <= 1'b0;
      upd_taken     <= 1'b0;
      upd_ghist     <= '0;
      upd_choice_en <= 1'b0;
      upd_choice_gp <= 1'b0;
      mispredict    <= 1'b0;
      recover_ghist <= '0;
      resolve_err   <= 1'b0;
    end else begin
      upd_valid  <= do_pop;
      mispredict <= mis_now;
      if (do_pop) begin
        upd_taken     <= resolve_taken;
        upd_ghist     <= head_ghist;
        upd_choice_en <= train[1];
        upd_choice_gp <= train[0];
      end
      if (mis_now) recover_ghist <= {head_ghist[HIST_W-2:0], resolve_taken};
      if (resolve_valid && (count == '0)) resolve_err <= 1'b1;
    end
  end

`ifdef BUQ_STATS_EN
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      stat_resolved <= '0;
      stat_mispred  <= '0;
    end else begin
      if (do_pop && (stat_resolved != '1)) stat_resolved <= stat_resolved + 32'd1;
      if (mis_now && (stat_mispred != '1)) stat_mispred <= stat_mispred + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_branch_update_queue.sv
// Scoreboard bench for branch_update_queue against a queue-based reference model.
module tb_branch_update_queue;

  localparam int DEPTH  = 8;
  localparam int HIST_W = 12;

  logic              clock = 1'b0;
  logic              reset = 1'b0;
  logic              pred_valid = 1'b0, pred_lp = 1'b0, pred_gp = 1'b0, pred_cp = 1'b0;
  logic [HIST_W-1:0] pred_ghist = '0;
  logic              resolve_valid = 1'b0, resolve_taken = 1'b0;
  logic              pred_ready, upd_valid, upd_taken, upd_choice_en, upd_choice_gp;
  logic              mispredict, resolve_err;
  logic [HIST_W-1:0] upd_ghist, recover_ghist;
  logic [3:0]        count;
`ifdef BUQ_STATS_EN
  logic [31:0]       stat_resolved, stat_mispred;
`endif

  branch_update_queue #(.DEPTH(DEPTH), .HIST_W(HIST_W)) dut (
    .clock(clock), .reset(reset),
    .pred_valid(pred_valid), .pred_ready(pred_ready),
    .pred_lp(pred_lp), .pred_gp(pred_gp), .pred_cp(pred_cp), .pred_ghist(pred_ghist),
    .resolve_valid(resolve_valid), .resolve_taken(resolve_taken),
    .upd_valid(upd_valid), .upd_taken(upd_taken), .upd_ghist(upd_ghist),
    .upd_choice_en(upd_choice_en), .upd_choice_gp(upd_choice_gp),
    .mispredict(mispredict), .recover_ghist(recover_ghist),
    .count(count), .resolve_err(resolve_err)
`ifdef BUQ_STATS_EN
    , .stat_resolved(stat_resolved), .stat_mispred(stat_mispred)
`endif
  );

  always #5 clock = ~clock;

  typedef struct {
    bit        lp, gp, cp;
    bit [11:0] ghist;
  } ent_t;

  typedef struct {
    bit        v, taken, cen, cgp, mis, ready, err;
    bit [11:0] gh, rg;
    int        cnt;
    longint    sr, sm;
  } exp_t;

  ent_t   mq[$];
  exp_t   eq[$];
  bit     m_err;
  longint m_sr, m_sm;
  int     tests, fails;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req);
    tests++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s actual=%0h required=%0h at %0t", nm, act, req, $time);
    end
  endtask

  // One clock of stimulus; the model computes what the following edge must produce.
  task automatic step(input bit pv, input bit lp, input bit gp, input bit cp,
                      input bit [11:0] gh, input bit rv, input bit rt);
    exp_t x;
    ent_t e, n;
    int   sz;
    bit   push, pop;
    @(negedge clock);
    pred_valid = pv; pred_lp = lp; pred_gp = gp; pred_cp = cp; pred_ghist = gh;
    resolve_valid = rv; resolve_taken = rt;
    x = '{default: 0};
    sz = mq.size();
    push = pv && (sz != DEPTH);
    pop  = rv && (sz != 0);
    if (rv && sz == 0) m_err = 1'b1;
    x.v = pop;
    if (pop) begin
      e = mq.pop_front();
      x.taken = rt;
      x.gh    = e.ghist;
      x.cen   = (e.lp != e.gp);
      x.cgp   = (e.gp == rt);
      x.mis   = (e.cp != rt);
      x.rg    = {e.ghist[10:0], rt};
      m_sr++;
      if (x.mis) begin
        m_sm++;
        mq.delete();
      end
    end
    if (push && !x.mis) begin
      n.lp = lp; n.gp = gp; n.cp = cp; n.ghist = gh;
      mq.push_back(n);
    end
    x.cnt   = mq.size();
    x.ready = (mq.size() != DEPTH);
    x.err   = m_err;
    x.sr    = m_sr;
    x.sm    = m_sm;
    eq.push_back(x);
  endtask

  task automatic idle();
    step(0, 0, 0, 0, 12'h0, 0, 0);
  endtask

  task automatic after_edge();
    @(posedge clock);
    #2;
  endtask

  // Monitor: pops the scoreboard once per edge that stimulus was issued for.
  initial begin
    exp_t x;
    forever begin
      @(posedge clock);
      #1;
      if (eq.size() != 0) begin
        x = eq.pop_front();
        chk("upd_valid", upd_valid, x.v);
        chk("mispredict", mispredict, x.mis);
        chk("count", count, x.cnt);
        chk("pred_ready", pred_ready, x.ready);
        chk("resolve_err", resolve_err, x.err);
        if (x.v) begin
          chk("upd_taken", upd_taken, x.taken);
          chk("upd_ghist", upd_ghist, x.gh);
          chk("upd_choice_en", upd_choice_en, x.cen);
          chk("upd_choice_gp", upd_choice_gp, x.cgp);
        end
        if (x.mis) chk("recover_ghist", recover_ghist, x.rg);
`ifdef BUQ_STATS_EN
        chk("stat_resolved", stat_resolved, x.sr);
        chk("stat_mispred", stat_mispred, x.sm);
`endif
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog timeout tests=%0d", tests);
    $fatal(1, "watchdog");
  end

  task automatic model_reset();
    mq.delete();
    m_err = 1'b0;
    m_sr = 0;
    m_sm = 0;
    pred_valid = 1'b0;
    resolve_valid = 1'b0;
  endtask

  initial begin
    bit        pv, rv, rt, cp;
    bit [11:0] gh;
    int        pushes;
    model_reset();
    #3;
    chk("rst_count", count, 0);
    chk("rst_upd_valid", upd_valid, 0);
    chk("rst_mispredict", mispredict, 0);
    chk("rst_resolve_err", resolve_err, 0);
    @(negedge clock);
    @(negedge clock);
    reset = 1'b1;
    #1;
    chk("rst_pred_ready", pred_ready, 1);

    // Three correct taken predictions, LP/GP disagree with GP wrong.
    repeat (3) step(1, 1, 0, 1, 12'h00A, 0, 0);
    step(0, 0, 0, 0, 12'h0, 1, 1);
    step(0, 0, 0, 0, 12'h0, 1, 1);
    step(0, 0, 0, 0, 12'h0, 1, 1);
    after_edge();
    chk("t1_upd_valid", upd_valid, 1);
    chk("t1_choice_en", upd_choice_en, 1);
    chk("t1_choice_gp", upd_choice_gp, 0);
    chk("t1_mispredict", mispredict, 0);
    chk("t1_count", count, 0);
    idle();

    // Fill, refused ninth push, then one pop frees a slot.
    for (int i = 0; i < DEPTH; i++) step(1, 0, 1, 1, 12'(i + 1), 0, 0);
    step(1, 1, 1, 1, 12'hFFF, 0, 0);
    after_edge();
    chk("t2_full_count", count, 8);
    chk("t2_full_ready", pred_ready, 0);
    step(1, 1, 1, 1, 12'hEEE, 1, 1);
    after_edge();
    chk("t2_count7", count, 7);
    chk("t2_ready", pred_ready, 1);
    repeat (7) step(0, 0, 0, 0, 12'h0, 1, 1);
    idle();

    // Mispredict on oldest flushes everything, including a same-cycle push.
    step(1, 0, 1, 1, 12'hABC, 0, 0);
    for (int i = 0; i < 3; i++) step(1, 1, 0, 0, 12'(i + 12'h100), 0, 0);
    step(1, 1, 1, 1, 12'h123, 1, 0);
    after_edge();
    chk("t3_mispredict", mispredict, 1);
    chk("t3_recover", recover_ghist, 12'h578);
    chk("t3_count", count, 0);
    idle();
    after_edge();
    chk("t3_push_dropped", count, 0);

    // Resolve on empty queue: no pulse, sticky error.
    step(0, 0, 0, 0, 12'h0, 1, 1);
    after_edge();
    chk("t4_no_pulse", upd_valid, 0);
    chk("t4_err", resolve_err, 1);
    repeat (3) idle();
    after_edge();
    chk("t4_err_sticky", resolve_err, 1);

    // Randomized traffic with wrap-around.
    pushes = 0;
    for (int i = 0; i < 400; i++) begin
      pv = ($urandom_range(0, 99) < 60);
      rv = ($urandom_range(0, 99) < 45);
      cp = 1'($urandom_range(0, 1));
      gh = 12'($urandom);
      if (mq.size() != 0 && $urandom_range(0, 99) < 85) rt = mq[0].cp;
      else rt = 1'($urandom_range(0, 1));
      if (pv && mq.size() != DEPTH) pushes++;
      step(pv, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), cp, gh, rv, rt);
    end
    chk("t5_enough_pushes", (pushes >= 20), 1);
    for (int i = 0; i < DEPTH + 2; i++) begin
      if (mq.size() != 0) step(0, 0, 0, 0, 12'h0, 1, mq[0].cp);
      else idle();
    end

    // Reset mid-stream with five entries queued and a pulse in flight.
    for (int i = 0; i < 5; i++) step(1, 1, 0, 1, 12'(12'h200 + i), 0, 0);
    step(1, 1, 0, 1, 12'h2FF, 1, 1);
    after_edge();
    reset = 1'b0;
    model_reset();
    #1;
    chk("t6_upd_valid", upd_valid, 0);
    chk("t6_mispredict", mispredict, 0);
    chk("t6_count", count, 0);
    chk("t6_err", resolve_err, 0);
    chk("t6_recover", recover_ghist, 0);
`ifdef BUQ_STATS_EN
    chk("t6_stat_resolved", stat_resolved, 0);
    chk("t6_stat_mispred", stat_mispred, 0);
`endif
    @(negedge clock);
    @(negedge clock);
    reset = 1'b1;
    after_edge();
    chk("t6_post_count", count, 0);
    chk("t6_post_ready", pred_ready, 1);
    step(1, 0, 0, 0, 12'h055, 0, 0);
    step(0, 0, 0, 0, 12'h0, 1, 0);
    idle();

    for (int i = 0; i < 10 && eq.size() != 0; i++) @(negedge clock);
    chk("scoreboard_drained", eq.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
